crc_frame_seq: RTL and testbench
================================

// Module: crc_frame_seq
// PURPOSE
//  Frame sequencer for the 8-bit-in / CRC-16 byte engine (`crc`).
//  - Passes a byte stream from an upstream valid/ready source to a downstream sink.
//  - Drives the engine's init/calc/d_valid controls.
//  - After the last payload byte, appends the two CRC bytes (high, then low) using the engine's shift-out mode.
//  - Sits between the packet framer and the line encoder; owns all sequencing of the engine instance.
// PARAMETERS
//  LEN_W       16  width of payload byte counter and frame counter
//  APPEND_CRC  1   1: append 2 CRC bytes; 0: pass-through only, engine still updated
// PORTS
//  clk          in   1      rising-edge clock; single clock domain
//  reset        in   1      synchronous, active-high; sampled on clk
//  s_data       in   8      upstream payload byte
//  s_valid      in   1      upstream byte valid
//  s_last       in   1      marks final payload byte of frame
//  s_ready      out  1      upstream accept
//  abort        in   1      drop current frame, resynchronise engine
//  m_data       out  8      downstream byte (payload or CRC)
//  m_valid      out  1      downstream valid
//  m_last       out  1      final byte of emitted frame
//  m_ready      in   1      downstream accept
//  crc_d        out  8      engine data input
//  crc_calc     out  1      engine calc (1 = accumulate, 0 = shift out)
//  crc_init     out  1      engine synchronous clear
//  crc_d_valid  out  1      engine byte strobe
//  crc_q        in   8      engine registered CRC output byte
//  frame_len    out  LEN_W  payload bytes accepted in current/last frame
//  len_ovf      out  1      sticky per frame: counter saturated at all-ones
//  frame_cnt    out  LEN_W  completed frames, wraps at 2^LEN_W
//  abort_pulse  out  1      1-cycle pulse when an abort is taken
// BEHAVIOUR
//  - FSM states: INIT, DATA, CRC_HI, CRC_LO. Reset -> INIT.
//  - Reset values: all outputs 0, except crc_init = 1 (state INIT).
//  - INIT:
//    - crc_init = 1, s_ready = 0, m_valid = 0.
//    - Clears frame_len and len_ovf.
//    - Next cycle -> DATA, always exactly one cycle.
//  - DATA:
//    - m_data = s_data, m_valid = s_valid, s_ready = m_ready (combinational pass-through).
//    - m_last = s_last & ~APPEND_CRC.
//    - On handshake (s_valid & s_ready): crc_d_valid = 1, crc_calc = 1, crc_d = s_data; frame_len += 1 (saturating, sets len_ovf).
//    - Handshake with s_last:
//      - APPEND_CRC = 1 -> CRC_HI.
//      - APPEND_CRC = 0 -> INIT, frame_cnt += 1.
//  - CRC_HI:
//    - m_data = crc_q (engine already holds ~bitrev(next_crc[15:8])), m_valid = 1, m_last = 0, s_ready = 0.
//    - On m_ready: crc_d_valid = 1, crc_calc = 0 (engine shifts, crc_q becomes low byte next cycle) -> CRC_LO.
//  - CRC_LO:
//    - m_data = crc_q, m_valid = 1, m_last = 1, s_ready = 0.
//    - On m_ready -> INIT, frame_cnt += 1.
//  - crc_d_valid never asserted outside a downstream handshake, so the engine state always matches the emitted bytes.
//  - abort (any state except INIT):
//    - Next state INIT; abort_pulse = 1.
//    - s_ready, m_valid, crc_d_valid forced 0 that cycle; abort wins over a same-cycle handshake.
//    - frame_cnt is not incremented.
//    - Already-emitted bytes are not recalled; the sink sees no m_last.
//  - abort in INIT: ignored, no pulse.
//  - reset mid-frame: same as abort, but all counters clear and abort_pulse stays 0.
//  - Latency: payload 0 cycles (combinational). CRC_HI is presented the cycle after the last-byte handshake.
//  - Back-to-back frames: 1-cycle bubble (INIT) between frames; minimum frame is 1 payload byte + 2 CRC bytes.
//  - frame_cnt wraps from all-ones to 0 without flag.
// STRUCTURE
//  - Shared package: state enum (INIT/DATA/CRC_HI/CRC_LO), CRC_BYTES = 2.
//  - No sub-module: single FSM + two counters. The `crc` engine is instantiated by the parent, not inside this block.
// TESTING (bench instantiates real `crc` engine; reset both)
//  1. Frame {8'h00}, m_ready = 1 -> m_data 00, FF, FF on consecutive handshakes; m_last on 3rd; frame_cnt = 1; frame_len = 1.
//  2. Same frame, m_ready low 3 cycles during CRC_HI -> m_data held at FF, crc_d_valid = 0 throughout stall; output identical to test 1.
//  3. 4-byte frame 01 02 03 04, random s_valid/m_ready -> CRC bytes equal bit-accurate model of engine; frame_len = 4.
//  4. abort asserted with a same-cycle byte handshake in DATA -> byte not counted, abort_pulse = 1, crc_init next cycle; next frame {00} gives 00, FF, FF.
//  5. LEN_W = 4, 20-byte frame -> frame_len = 15, len_ovf = 1; CRC still appended; len_ovf cleared in INIT.
//  6. APPEND_CRC = 0, frame 0A 0B (last) -> m_last on 0B, no CRC bytes; one INIT bubble before the next frame.

Source files
------------

// File: rtl/crc_frame_seq_pkg.sv
// Shared types for the CRC frame sequencer: FSM state encoding and CRC framing constants.
package crc_frame_seq_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CRC_BYTES = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_CRC_HI = 2'd2,
        ST_CRC_LO = 2'd3
    } state_t;

endpackage

// File: rtl/crc_frame_seq.sv
// Frame sequencer for the byte-wide CRC-16 engine: passes payload through, drives the engine
// controls and appends the two CRC bytes (high, then low) using the engine's shift-out mode.
module crc_frame_seq
    import crc_frame_seq_pkg::*;
#(
    parameter int unsigned LEN_W      = 16,
    parameter bit          APPEND_CRC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              abort,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] crc_d,
    output logic              crc_calc,
    output logic              crc_init,
    output logic              crc_d_valid,
    input  logic [BYTE_W-1:0] crc_q,
    output logic [LEN_W-1:0]  frame_len,
    output logic              len_ovf,
    output logic [LEN_W-1:0]  frame_cnt,
    output logic              abort_pulse
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_frame_len;
    logic [LEN_W-1:0] r_frame_cnt;
    logic             r_len_ovf;
    logic             r_abort_pulse;
    logic             w_take_abort;
    logic             w_s_hs;
    logic             w_frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, stream steering and engine controls; abort overrides everything outside INIT
    always_comb begin
        w_state_nxt  = r_state;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        m_data       = '0;
        crc_d        = '0;
        crc_calc     = 1'b0;
        crc_init     = 1'b0;
        crc_d_valid  = 1'b0;
        w_take_abort = 1'b0;
        w_s_hs       = 1'b0;
        w_frame_done = 1'b0;

        unique case (r_state)
            ST_INIT: begin
                crc_init    = 1'b1;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                m_data  = s_data;
                m_valid = s_valid;
                s_ready = m_ready;
                m_last  = APPEND_CRC ? 1'b0 : s_last;
                crc_d   = s_data;
                if (s_valid && m_ready) begin
                    w_s_hs      = 1'b1;
                    crc_d_valid = 1'b1;
                    crc_calc    = 1'b1;
                    if (s_last) begin
                        if (APPEND_CRC) begin
                            w_state_nxt = ST_CRC_HI;
                        end else begin
                            w_state_nxt  = ST_INIT;
                            w_frame_done = 1'b1;
                        end
                    end
                end
            end
            ST_CRC_HI: begin
                m_data  = crc_q;
                m_valid = 1'b1;
                if (m_ready) begin
                    crc_d_valid = 1'b1;
                    w_state_nxt = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                m_data  = crc_q;
                m_valid = 1'b1;
                m_last  = 1'b1;
                if (m_ready) begin
                    w_state_nxt  = ST_INIT;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase

        if (abort && (r_state != ST_INIT)) begin
            w_take_abort = 1'b1;
            w_state_nxt  = ST_INIT;
            s_ready      = 1'b0;
            m_valid      = 1'b0;
            m_last       = 1'b0;
            crc_d_valid  = 1'b0;
            crc_calc     = 1'b0;
            w_s_hs       = 1'b0;
            w_frame_done = 1'b0;
        end
    end

    // Length counter saturates; overflow flags a byte accepted while already at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_len   <= '0;
            r_len_ovf     <= 1'b0;
            r_frame_cnt   <= '0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_abort_pulse <= w_take_abort;
            if (r_state == ST_INIT) begin
                r_frame_len <= '0;
                r_len_ovf   <= 1'b0;
            end else if (w_s_hs) begin
                if (&r_frame_len) begin
                    r_len_ovf <= 1'b1;
                end else begin
                    r_frame_len <= r_frame_len + LEN_W'(1);
                end
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + LEN_W'(1);
            end
        end
    end

    assign frame_len   = r_frame_len;
    assign len_ovf     = r_len_ovf;
    assign frame_cnt   = r_frame_cnt;
    assign abort_pulse = r_abort_pulse;

endmodule

// File: tb/tb_crc_frame_seq.sv
// Bench for crc_frame_seq: three instances (default, LEN_W=4, APPEND_CRC=0), each with a CRC-16 engine model.
module tb_crc_frame_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid, s_last, m_ready, abort;
    int         sel = 0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    logic       s_valid_a, s_valid_b, s_valid_c, abort_a, abort_b, abort_c;
    assign s_valid_a = s_valid && (sel == 0);
    assign s_valid_b = s_valid && (sel == 1);
    assign s_valid_c = s_valid && (sel == 2);
    assign abort_a   = abort && (sel == 0);
    assign abort_b   = abort && (sel == 1);
    assign abort_c   = abort && (sel == 2);

    logic [7:0]  m_data_a, m_data_b, m_data_c, crc_d_a, crc_d_b, crc_d_c;
    logic        m_valid_a, m_valid_b, m_valid_c, m_last_a, m_last_b, m_last_c;
    logic        s_ready_a, s_ready_b, s_ready_c;
    logic        calc_a, calc_b, calc_c, init_a, init_b, init_c, dv_a, dv_b, dv_c;
    logic        ovf_a, ovf_b, ovf_c, ap_a, ap_b, ap_c;
    logic [15:0] flen_a, fcnt_a, flen_c, fcnt_c;
    logic [3:0]  flen_b, fcnt_b;
    logic [15:0] e_reg_a, e_reg_b, e_reg_c;
    logic [7:0]  e_q_a, e_q_b, e_q_c;

    crc_frame_seq #(.LEN_W(16), .APPEND_CRC(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last),
        .s_ready(s_ready_a), .abort(abort_a), .m_data(m_data_a), .m_valid(m_valid_a),
        .m_last(m_last_a), .m_ready(m_ready), .crc_d(crc_d_a), .crc_calc(calc_a),
        .crc_init(init_a), .crc_d_valid(dv_a), .crc_q(e_q_a), .frame_len(flen_a),
        .len_ovf(ovf_a), .frame_cnt(fcnt_a), .abort_pulse(ap_a));

    crc_frame_seq #(.LEN_W(4), .APPEND_CRC(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last),
        .s_ready(s_ready_b), .abort(abort_b), .m_data(m_data_b), .m_valid(m_valid_b),
        .m_last(m_last_b), .m_ready(m_ready), .crc_d(crc_d_b), .crc_calc(calc_b),
        .crc_init(init_b), .crc_d_valid(dv_b), .crc_q(e_q_b), .frame_len(flen_b),
        .len_ovf(ovf_b), .frame_cnt(fcnt_b), .abort_pulse(ap_b));

    crc_frame_seq #(.LEN_W(16), .APPEND_CRC(1'b0)) u_dut_c (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_c), .s_last(s_last),
        .s_ready(s_ready_c), .abort(abort_c), .m_data(m_data_c), .m_valid(m_valid_c),
        .m_last(m_last_c), .m_ready(m_ready), .crc_d(crc_d_c), .crc_calc(calc_c),
        .crc_init(init_c), .crc_d_valid(dv_c), .crc_q(e_q_c), .frame_len(flen_c),
        .len_ovf(ovf_c), .frame_cnt(fcnt_c), .abort_pulse(ap_c));

    // CRC-16 engine (poly 0x8005, init 0, MSB first); crc_q holds the inverted bit-reversed byte
    function automatic logic [15:0] eng_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        logic        fb;
        x = c;
        for (int i = 7; i >= 0; i--) begin
            fb = x[15] ^ d[i];
            x  = {x[14:0], 1'b0};
            if (fb) x = x ^ 16'h8005;
        end
        return x;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    logic [15:0] nxt_a, nxt_b, nxt_c;
    assign nxt_a = eng_step(e_reg_a, crc_d_a);
    assign nxt_b = eng_step(e_reg_b, crc_d_b);
    assign nxt_c = eng_step(e_reg_c, crc_d_c);

    always @(posedge clk) begin
        if (reset || init_a) begin e_reg_a <= '0; e_q_a <= '0; end
        else if (dv_a && calc_a) begin e_reg_a <= nxt_a; e_q_a <= ~bitrev8(nxt_a[15:8]); end
        else if (dv_a) begin e_reg_a <= {e_reg_a[7:0], 8'h00}; e_q_a <= ~bitrev8(e_reg_a[7:0]); end
    end
    always @(posedge clk) begin
        if (reset || init_b) begin e_reg_b <= '0; e_q_b <= '0; end
        else if (dv_b && calc_b) begin e_reg_b <= nxt_b; e_q_b <= ~bitrev8(nxt_b[15:8]); end
        else if (dv_b) begin e_reg_b <= {e_reg_b[7:0], 8'h00}; e_q_b <= ~bitrev8(e_reg_b[7:0]); end
    end
    always @(posedge clk) begin
        if (reset || init_c) begin e_reg_c <= '0; e_q_c <= '0; end
        else if (dv_c && calc_c) begin e_reg_c <= nxt_c; e_q_c <= ~bitrev8(nxt_c[15:8]); end
        else if (dv_c) begin e_reg_c <= {e_reg_c[7:0], 8'h00}; e_q_c <= ~bitrev8(e_reg_c[7:0]); end
    end

    logic [7:0]  mon_m_data;
    logic        mon_m_valid, mon_m_last, mon_s_ready, mon_dv, mon_init, mon_ovf, mon_ap;
    logic [15:0] mon_flen, mon_fcnt;

    always_comb begin
        mon_m_data = m_data_a; mon_m_valid = m_valid_a; mon_m_last = m_last_a;
        mon_s_ready = s_ready_a; mon_dv = dv_a; mon_init = init_a; mon_ovf = ovf_a;
        mon_ap = ap_a; mon_flen = flen_a; mon_fcnt = fcnt_a;
        if (sel == 1) begin
            mon_m_data = m_data_b; mon_m_valid = m_valid_b; mon_m_last = m_last_b;
            mon_s_ready = s_ready_b; mon_dv = dv_b; mon_init = init_b; mon_ovf = ovf_b;
            mon_ap = ap_b; mon_flen = 16'(flen_b); mon_fcnt = 16'(fcnt_b);
        end else if (sel == 2) begin
            mon_m_data = m_data_c; mon_m_valid = m_valid_c; mon_m_last = m_last_c;
            mon_s_ready = s_ready_c; mon_dv = dv_c; mon_init = init_c; mon_ovf = ovf_c;
            mon_ap = ap_c; mon_flen = flen_c; mon_fcnt = fcnt_c;
        end
    end

    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic        rxl_q[$];
    logic [15:0] len_at_end;
    logic        ovf_at_end;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference CRC: remainder of (message * x^16) divided by x^16+x^15+x^2+1
    function automatic logic [15:0] ref_crc();
        bit          msg[$];
        logic [16:0] poly;
        logic [15:0] r;
        poly = 17'h18005;
        foreach (tx_q[i]) for (int b = 7; b >= 0; b--) msg.push_back(tx_q[i][b]);
        for (int k = 0; k < 16; k++) msg.push_back(1'b0);
        for (int i = 0; i + 16 < msg.size(); i++)
            if (msg[i]) for (int j = 0; j < 17; j++) msg[i+j] = msg[i+j] ^ poly[16-j];
        for (int k = 0; k < 16; k++) r[15-k] = msg[msg.size()-16+k];
        return r;
    endfunction

    task automatic build_exp(input bit append);
        logic [15:0] r;
        exp_q = tx_q;
        if (append) begin
            r = ref_crc();
            exp_q.push_back(~bitrev8(r[15:8]));
            exp_q.push_back(~bitrev8(r[7:0]));
        end
    endtask

    task automatic rand_tx(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic idle(input bit ab);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; abort = ab; s_data = 8'h00;
        #1;
    endtask

    // mode 0: always ready; 1: random valid/ready; 2: ready, but 3 stall cycles in CRC_HI
    task automatic run_frame(input int mode, input string tag);
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        bit done = 0;
        int n = tx_q.size();
        bit stalling;
        rx_q.delete(); rxl_q.delete();
        while (!done && cyc < 500) begin
            @(negedge clk);
            abort    = 1'b0;
            s_valid  = (idx < n) && (mode != 1 || $urandom_range(0, 1) == 1);
            s_data   = (idx < n) ? tx_q[idx] : 8'h00;
            s_last   = (idx == n - 1);
            m_ready  = (mode != 1) || ($urandom_range(0, 3) != 0);
            stalling = (mode == 2) && (rx_q.size() == n) && (stall < 3);
            if (stalling) m_ready = 1'b0;
            #1;
            if (stalling) begin
                chk($sformatf("%s_stall_data", tag), 32'(mon_m_data), 32'(exp_q[n]));
                chk($sformatf("%s_stall_dv", tag), 32'(mon_dv), 32'd0);
                stall++;
            end
            if (mon_m_valid && m_ready) begin
                rx_q.push_back(mon_m_data);
                rxl_q.push_back(mon_m_last);
                if (mon_m_last) begin
                    done = 1;
                    len_at_end = mon_flen;
                    ovf_at_end = mon_ovf;
                end
            end
            if (s_valid && mon_s_ready) idx++;
            cyc++;
        end
        chk($sformatf("%s_done", tag), 32'(done), 32'd1);
        chk($sformatf("%s_nbytes", tag), 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i),
                (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
            chk($sformatf("%s_last%0d", tag, i),
                (i < rxl_q.size()) ? 32'(rxl_q[i]) : 32'hFFFF_FFFF, 32'(i == exp_q.size() - 1));
        end
    endtask

    initial begin
        reset = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1; abort = 1'b0;
        sel = 0; exp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_crc_init", 32'(mon_init), 32'd1);
        chk("rst_m_valid", 32'(mon_m_valid), 32'd0);
        chk("rst_s_ready", 32'(mon_s_ready), 32'd0);
        chk("rst_m_data", 32'(mon_m_data), 32'd0);
        chk("rst_frame_len", 32'(mon_flen), 32'd0);
        chk("rst_frame_cnt", 32'(mon_fcnt), 32'd0);
        chk("rst_abort_pulse", 32'(mon_ap), 32'd0);
        reset = 1'b0;

        // 1-byte zero frame, always ready
        tx_q = '{8'h00}; build_exp(1'b1);
        run_frame(0, "t1");
        chk("t1_frame_len", 32'(len_at_end), 32'd1);
        idle(1'b0); exp_cnt++;
        chk("t1_frame_cnt", 32'(mon_fcnt), 32'(exp_cnt));
        chk("t1_bubble_init", 32'(mon_init), 32'd1);

        // same frame with downstream stall in CRC_HI
        run_frame(2, "t2");
        idle(1'b0); exp_cnt++;
        chk("t2_frame_cnt", 32'(mon_fcnt), 32'(exp_cnt));

        // 4-byte frame with random handshakes
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04}; build_exp(1'b1);
        run_frame(1, "t3");
        chk("t3_frame_len", 32'(len_at_end), 32'd4);
        idle(1'b0); exp_cnt++;
        chk("t3_frame_cnt", 32'(mon_fcnt), 32'(exp_cnt));

        for (int f = 0; f < 5; f++) begin
            rand_tx($urandom_range(1, 7)); build_exp(1'b1);
            run_frame(1, $sformatf("rnd%0d", f));
            chk($sformatf("rnd%0d_len", f), 32'(len_at_end), 32'(tx_q.size()));
            idle(1'b0); exp_cnt++;
            chk($sformatf("rnd%0d_cnt", f), 32'(mon_fcnt), 32'(exp_cnt));
        end

        // abort colliding with a byte handshake
        @(negedge clk); s_valid = 1'b1; s_data = 8'hAB; s_last = 1'b0; m_ready = 1'b1; #1;
        chk("t4_first_accept", 32'(mon_s_ready), 32'd1);
        @(negedge clk); s_data = 8'hCD; abort = 1'b1; #1;
        chk("t4_abort_s_ready", 32'(mon_s_ready), 32'd0);
        chk("t4_abort_m_valid", 32'(mon_m_valid), 32'd0);
        chk("t4_abort_dv", 32'(mon_dv), 32'd0);
        idle(1'b0);
        chk("t4_abort_pulse", 32'(mon_ap), 32'd1);
        chk("t4_crc_init", 32'(mon_init), 32'd1);
        chk("t4_frame_len", 32'(mon_flen), 32'd1);
        chk("t4_frame_cnt", 32'(mon_fcnt), 32'(exp_cnt));
        tx_q = '{8'h00}; build_exp(1'b1);
        run_frame(0, "t4_next");
        idle(1'b1); exp_cnt++;
        chk("t4_next_cnt", 32'(mon_fcnt), 32'(exp_cnt));
        idle(1'b0);
        chk("t4_init_abort_ignored", 32'(mon_ap), 32'd0);
        chk("t4_init_abort_left_init", 32'(mon_init), 32'd0);

        // reset in the middle of a frame
        @(negedge clk); s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0; m_ready = 1'b1; abort = 1'b0; #1;
        @(negedge clk); s_valid = 1'b0; reset = 1'b1; #1;
        @(negedge clk); reset = 1'b0; #1;
        exp_cnt = 0;
        chk("rmid_abort_pulse", 32'(mon_ap), 32'd0);
        chk("rmid_frame_cnt", 32'(mon_fcnt), 32'd0);
        chk("rmid_frame_len", 32'(mon_flen), 32'd0);
        chk("rmid_crc_init", 32'(mon_init), 32'd1);
        rand_tx(3); build_exp(1'b1);
        run_frame(1, "rmid_next");
        idle(1'b0); exp_cnt++;
        chk("rmid_next_cnt", 32'(mon_fcnt), 32'(exp_cnt));

        // LEN_W = 4: 20-byte frame saturates the length counter
        sel = 1;
        idle(1'b0);
        rand_tx(20); build_exp(1'b1);
        run_frame(0, "t5");
        chk("t5_frame_len", 32'(len_at_end), 32'd15);
        chk("t5_len_ovf", 32'(ovf_at_end), 32'd1);
        idle(1'b0);
        chk("t5_frame_cnt", 32'(mon_fcnt), 32'd1);
        chk("t5_ovf_in_init", 32'(mon_ovf), 32'd1);
        idle(1'b0);
        chk("t5_ovf_cleared", 32'(mon_ovf), 32'd0);
        chk("t5_len_cleared", 32'(mon_flen), 32'd0);

        // APPEND_CRC = 0: pass-through only, single INIT bubble between frames
        sel = 2;
        idle(1'b0);
        tx_q = '{8'h0A, 8'h0B}; build_exp(1'b0);
        run_frame(0, "t6");
        idle(1'b0);
        chk("t6_bubble_init", 32'(mon_init), 32'd1);
        chk("t6_frame_len", 32'(mon_flen), 32'd2);
        chk("t6_frame_cnt", 32'(mon_fcnt), 32'd1);
        @(negedge clk); s_valid = 1'b1; s_data = 8'h11; s_last = 1'b1; m_ready = 1'b1; #1;
        chk("t6_next_accept", 32'(mon_s_ready), 32'd1);
        chk("t6_next_m_last", 32'(mon_m_last), 32'd1);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
